data_bus_responder: RTL and testbench
=====================================

// Module: data_bus_responder
// PURPOSE
//  Target end of the CPU data bus: decodes the CPU's address/write-data/write-length/write-enable and serves
//  load data back on the read-data bus. Hosts the data RAM plus a small MMIO bank:
//  64-bit cycle timer with compare/IRQ, GPIO output register, sticky bus-error flag. Sits beside the CPU in the SoC top.
// PARAMETERS
//  DATA_WORDS   1024          RAM depth in 32-bit words (power of two); RAM at 0x0000_0000..DATA_WORDS*4-1
//  MMIO_BASE    32'h1000_0000 base of MMIO window (64-byte window, addr[5:2] selects register)
//  GPIO_WIDTH   8             width of o_gpio
// PORTS
//  clk                 in   1     rising-edge clock
//  i_reset_n           in   1     asynchronous, active-low reset
//  i_bus_address       in   32    byte address from CPU
//  i_bus_wr_data       in   32    store data, LSB-aligned (byte in [7:0], half in [15:0])
//  i_bus_write_length  in   3     store size: 3'b000 byte, 3'b001 half, 3'b010 word, others = no write
//  i_bus_wr_enable     in   1     write strobe, sampled on clk rising edge
//  o_bus_read_data     out  32    aligned word at {addr[31:2],2'b00}, combinational
//  o_timer_irq         out  1     registered, high while mtime >= mtimecmp (unsigned 64-bit)
//  o_gpio              out  GPIO_WIDTH  GPIO output register
//  o_bus_error         out  1     sticky error flag (= STATUS[1])
// BEHAVIOUR
//  - Reset (async assert, sync-released use): mtime=0, mtimecmp=64'hFFFF_FFFF_FFFF_FFFF, gpio=0, error=0,
//    o_timer_irq=0. RAM contents are NOT reset.
//  - Reads: zero-latency combinational (single-cycle CPU); no read strobe, so reads have no side effects.
//    Unmapped address reads 32'h0. Byte/half extraction and sign extension are the CPU's job.
//  - Writes: committed on the rising edge when i_bus_wr_enable=1; byte lanes from write_length and addr[1:0]:
//    byte -> lane addr[1:0] gets wr_data[7:0]; half -> lanes {addr[1],0},+1 get wr_data[15:0]; word -> all lanes.
//  - Misaligned (half with addr[0]=1, word with addr[1:0]!=0), reserved length, or unmapped address with
//    wr_enable=1: no state changes, error flag set next edge.
//  - MMIO map (offset from MMIO_BASE): 0x00 MTIME_LO, 0x04 MTIME_HI, 0x08 MTIMECMP_LO, 0x0C MTIMECMP_HI,
//    0x10 STATUS {30'b0, error, timer_pending} (bit1 write-1-to-clear, bit0 read-only), 0x14 GPIO (low GPIO_WIDTH bits,
//    upper bits read 0). 0x18..0x3C unmapped. Sub-word writes to MMIO registers merge by lane like RAM.
//  - mtime increments by 1 every cycle, carry from LO into HI (wraps 2^64-1 -> 0). A write to MTIME_LO or
//    MTIME_HI in a cycle replaces that half with the merged write value; no increment that cycle for the
//    written half, and a carry from LO into HI is suppressed when LO is written.
//  - o_timer_irq = registered (mtime_next >= mtimecmp_next), i.e. tracks the post-edge register values; updates
//    one edge after a compare-changing write. timer_pending in STATUS = o_timer_irq.
//  - STATUS write with bit1=1 clears error; if an erroring write and a clearing write coincide (impossible on one
//    port) no priority needed. Error set has priority over nothing else; clear happens only via STATUS write.
//  - Reset asserted mid-operation: all registers clear immediately; a write in flight that cycle is lost.
// STRUCTURE
//  - Shared header parameters.vh: BUS_LEN_BYTE/HALF/WORD encodings, MMIO_BASE default, MMIO register offsets.
//  - One sub-module: bus_timer64 (mtime/mtimecmp regs, lane-merged write ports, carry, compare, irq register).
//  - Top: address decode, lane-mask generation, RAM array, GPIO/STATUS regs, read mux.
// TESTING
//  1. Reset low 3 cycles -> o_bus_read_data at 0x1000_0008/0C = FFFF_FFFF, o_gpio=0, o_timer_irq=0, o_bus_error=0.
//  2. Word 0xDEADBEEF @0x10, byte 0x55 @0x11, half 0xA5A5 @0x12 -> read 0x10 = 0xA5A555EF.
//  3. Half write @0x13 and word write @0x06 -> RAM unchanged, o_bus_error=1; write 0x2 to 0x1000_0010 -> error=0.
//  4. Write MTIME_LO=0xFFFF_FFFE, then idle 3 cycles -> MTIME_HI=1, MTIME_LO=1 (carry across halves).
//  5. MTIMECMP_HI=0, MTIMECMP_LO=mtime+5 -> o_timer_irq rises exactly when mtime reaches cmp; MTIMECMP_HI=1 -> irq low next edge.
//  6. Write 0xFFFF_FF3C to GPIO, read unmapped 0x1000_0020 and 0x2000_0000 -> o_gpio=0x3C, GPIO reads 0x3C, unmapped read 0.

Source files
------------

// File: rtl/data_bus_responder_pkg.sv
// Shared definitions for the CPU data-bus responder.
//   - Store-size encodings carried on i_bus_write_length
//   - MMIO register indices (addr[5:2] within the 64-byte window)
//   - Lane helpers: byte-lane mask, write-data replication, lane merge
package data_bus_responder_pkg;

    typedef enum logic [2:0] {
        BUS_LEN_BYTE = 3'b000,
        BUS_LEN_HALF = 3'b001,
        BUS_LEN_WORD = 3'b010
    } bus_len_e;

    typedef enum logic [3:0] {
        REG_MTIME_LO    = 4'd0,
        REG_MTIME_HI    = 4'd1,
        REG_MTIMECMP_LO = 4'd2,
        REG_MTIMECMP_HI = 4'd3,
        REG_STATUS      = 4'd4,
        REG_GPIO        = 4'd5
    } mmio_reg_e;

    localparam logic [31:0] MMIO_BASE_DEFAULT = 32'h1000_0000;

    // Byte lanes touched by a store; all-zero means the store is misaligned
    // or uses a reserved length and must not change any state.
    function automatic logic [3:0] lane_mask(input logic [2:0] len, input logic [1:0] offs);
        logic [3:0] mask;
        case (len)
            BUS_LEN_BYTE: mask = 4'b0001 << offs;
            BUS_LEN_HALF: mask = offs[0] ? 4'b0000 : (offs[1] ? 4'b1100 : 4'b0011);
            BUS_LEN_WORD: mask = (offs == 2'b00) ? 4'b1111 : 4'b0000;
            default:      mask = 4'b0000;
        endcase
        return mask;
    endfunction

    // Store data arrives LSB-aligned; replicating it puts the right bytes on
    // every lane the mask could select.
    function automatic logic [31:0] lane_replicate(input logic [2:0] len, input logic [31:0] data);
        logic [31:0] rep;
        case (len)
            BUS_LEN_BYTE: rep = {4{data[7:0]}};
            BUS_LEN_HALF: rep = {2{data[15:0]}};
            default:      rep = data;
        endcase
        return rep;
    endfunction

    function automatic logic [31:0] lane_merge(input logic [31:0] old, input logic [31:0] wdata,
                                               input logic [3:0] mask);
        logic [31:0] res;
        res = old;
        for (int unsigned i = 0; i < 4; i++) begin
            if (mask[i]) res[8*i +: 8] = wdata[8*i +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/bus_timer64.sv
// 64-bit free-running cycle timer with compare and registered IRQ.
// Ports:
//   clk, i_reset_n             clock, asynchronous active-low reset
//   i_wdata, i_lane_mask       lane-replicated store data and byte-lane mask
//   i_we_mtime_lo/hi           write strobes for the mtime halves
//   i_we_cmp_lo/hi             write strobes for the mtimecmp halves
//   o_mtime, o_mtimecmp        current register values
//   o_irq                      registered (mtime >= mtimecmp) of post-edge values
module bus_timer64
    import data_bus_responder_pkg::*;
(
    input  logic        clk,
    input  logic        i_reset_n,
    input  logic [31:0] i_wdata,
    input  logic [3:0]  i_lane_mask,
    input  logic        i_we_mtime_lo,
    input  logic        i_we_mtime_hi,
    input  logic        i_we_cmp_lo,
    input  logic        i_we_cmp_hi,
    output logic [63:0] o_mtime,
    output logic [63:0] o_mtimecmp,
    output logic        o_irq
);

    logic [31:0] mtime_lo, mtime_hi, cmp_lo, cmp_hi;
    logic [31:0] mtime_lo_next, mtime_hi_next, cmp_lo_next, cmp_hi_next;
    logic        lo_carry;

    always_comb begin
        // A written low half neither increments nor carries into the high half.
        lo_carry      = (mtime_lo == '1) && !i_we_mtime_lo;
        mtime_lo_next = i_we_mtime_lo ? lane_merge(mtime_lo, i_wdata, i_lane_mask)
                                      : mtime_lo + 32'd1;
        mtime_hi_next = i_we_mtime_hi ? lane_merge(mtime_hi, i_wdata, i_lane_mask)
                                      : mtime_hi + {31'b0, lo_carry};
        cmp_lo_next   = i_we_cmp_lo ? lane_merge(cmp_lo, i_wdata, i_lane_mask) : cmp_lo;
        cmp_hi_next   = i_we_cmp_hi ? lane_merge(cmp_hi, i_wdata, i_lane_mask) : cmp_hi;
    end

    always_ff @(posedge clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            mtime_lo <= '0;
            mtime_hi <= '0;
            cmp_lo   <= '1;
            cmp_hi   <= '1;
            o_irq    <= 1'b0;
        end else begin
            mtime_lo <= mtime_lo_next;
            mtime_hi <= mtime_hi_next;
            cmp_lo   <= cmp_lo_next;
            cmp_hi   <= cmp_hi_next;
            o_irq    <= {mtime_hi_next, mtime_lo_next} >= {cmp_hi_next, cmp_lo_next};
        end
    end

    assign o_mtime    = {mtime_hi, mtime_lo};
    assign o_mtimecmp = {cmp_hi, cmp_lo};

endmodule

// File: rtl/data_bus_responder.sv
// Target end of the CPU data bus: data RAM plus a small MMIO bank
// (64-bit timer/compare, GPIO output register, sticky bus-error flag).
// Ports:
//   clk, i_reset_n        clock, asynchronous active-low reset
//   i_bus_address         byte address from the CPU
//   i_bus_wr_data         LSB-aligned store data
//   i_bus_write_length    store size (byte/half/word, others reserved)
//   i_bus_wr_enable       write strobe sampled on the rising edge
//   o_bus_read_data       combinational aligned read word (0 when unmapped)
//   o_timer_irq           registered timer interrupt
//   o_gpio                GPIO output register
//   o_bus_error           sticky error flag (STATUS bit 1)
module data_bus_responder
    import data_bus_responder_pkg::*;
#(
    parameter int unsigned DATA_WORDS = 1024,
    parameter logic [31:0] MMIO_BASE  = MMIO_BASE_DEFAULT,
    parameter int unsigned GPIO_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  i_reset_n,
    input  logic [31:0]           i_bus_address,
    input  logic [31:0]           i_bus_wr_data,
    input  logic [2:0]            i_bus_write_length,
    input  logic                  i_bus_wr_enable,
    output logic [31:0]           o_bus_read_data,
    output logic                  o_timer_irq,
    output logic [GPIO_WIDTH-1:0] o_gpio,
    output logic                  o_bus_error
);

    localparam int unsigned RAM_AW = $clog2(DATA_WORDS);

    logic [31:0]       ram [DATA_WORDS];
    logic [RAM_AW-1:0] ram_idx;
    logic              ram_hit, mmio_hit, reg_hit;
    logic [3:0]        reg_idx;
    logic [3:0]        mask;
    logic [31:0]       wdata_rep;
    logic              wr_ok, wr_bad, reg_we, ram_we;
    logic [63:0]       mtime, mtimecmp;
    logic [31:0]       gpio_word;
    logic              error_q;

    assign ram_hit   = (i_bus_address[31:RAM_AW+2] == '0);
    assign ram_idx   = i_bus_address[RAM_AW+1:2];
    assign mmio_hit  = (i_bus_address[31:6] == MMIO_BASE[31:6]);
    assign reg_idx   = i_bus_address[5:2];
    assign reg_hit   = mmio_hit && (reg_idx <= REG_GPIO);

    assign mask      = lane_mask(i_bus_write_length, i_bus_address[1:0]);
    assign wdata_rep = lane_replicate(i_bus_write_length, i_bus_wr_data);

    assign wr_ok     = i_bus_wr_enable && (mask != '0) && (ram_hit || reg_hit);
    assign wr_bad    = i_bus_wr_enable && !wr_ok;
    assign reg_we    = wr_ok && reg_hit;
    // RAM has no reset, so gate it explicitly to drop a store in flight during reset.
    assign ram_we    = wr_ok && ram_hit && i_reset_n;

    always_ff @(posedge clk) begin
        if (ram_we) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (mask[i]) ram[ram_idx][8*i +: 8] <= wdata_rep[8*i +: 8];
            end
        end
    end

    bus_timer64 u_timer (
        .clk           (clk),
        .i_reset_n     (i_reset_n),
        .i_wdata       (wdata_rep),
        .i_lane_mask   (mask),
        .i_we_mtime_lo (reg_we && (reg_idx == REG_MTIME_LO)),
        .i_we_mtime_hi (reg_we && (reg_idx == REG_MTIME_HI)),
        .i_we_cmp_lo   (reg_we && (reg_idx == REG_MTIMECMP_LO)),
        .i_we_cmp_hi   (reg_we && (reg_idx == REG_MTIMECMP_HI)),
        .o_mtime       (mtime),
        .o_mtimecmp    (mtimecmp),
        .o_irq         (o_timer_irq)
    );

    assign gpio_word = 32'(o_gpio);

    always_ff @(posedge clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_gpio  <= '0;
            error_q <= 1'b0;
        end else begin
            if (reg_we && (reg_idx == REG_GPIO)) begin
                o_gpio <= GPIO_WIDTH'(lane_merge(gpio_word, wdata_rep, mask));
            end
            // W1C only counts when lane 0 (holding bit 1) is actually written.
            if (wr_bad) begin
                error_q <= 1'b1;
            end else if (reg_we && (reg_idx == REG_STATUS) && mask[0] && wdata_rep[1]) begin
                error_q <= 1'b0;
            end
        end
    end

    assign o_bus_error = error_q;

    always_comb begin
        o_bus_read_data = '0;
        if (ram_hit) begin
            o_bus_read_data = ram[ram_idx];
        end else if (mmio_hit) begin
            case (reg_idx)
                REG_MTIME_LO:    o_bus_read_data = mtime[31:0];
                REG_MTIME_HI:    o_bus_read_data = mtime[63:32];
                REG_MTIMECMP_LO: o_bus_read_data = mtimecmp[31:0];
                REG_MTIMECMP_HI: o_bus_read_data = mtimecmp[63:32];
                REG_STATUS:      o_bus_read_data = {30'b0, error_q, o_timer_irq};
                REG_GPIO:        o_bus_read_data = gpio_word;
                default:         o_bus_read_data = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_data_bus_responder.sv
// Self-checking bench for data_bus_responder against a byte-addressed
// behavioural model of memory, MMIO registers and a 64-bit timer.
module tb_data_bus_responder;

    localparam int unsigned DW   = 1024;
    localparam logic [31:0] BASE = 32'h1000_0000;
    localparam int unsigned GW   = 8;

    logic          clk       = 1'b0;
    logic          i_reset_n = 1'b0;
    logic [31:0]   addr      = '0;
    logic [31:0]   wdata     = '0;
    logic [2:0]    wlen      = 3'b111;
    logic          we        = 1'b0;
    logic [31:0]   rdata;
    logic          irq;
    logic [GW-1:0] gpio;
    logic          berr;

    int checks   = 0;
    int failures = 0;

    // Behavioural model state
    logic [7:0]    mem_b [DW*4];
    logic [63:0]   m_time = '0;
    logic [63:0]   m_cmp  = '1;
    logic [GW-1:0] m_gpio = '0;
    logic          m_err  = 1'b0;
    logic          m_irq  = 1'b0;

    data_bus_responder #(.DATA_WORDS(DW), .MMIO_BASE(BASE), .GPIO_WIDTH(GW)) dut (
        .clk                (clk),
        .i_reset_n          (i_reset_n),
        .i_bus_address      (addr),
        .i_bus_wr_data      (wdata),
        .i_bus_write_length (wlen),
        .i_bus_wr_enable    (we),
        .o_bus_read_data    (rdata),
        .o_timer_irq        (irq),
        .o_gpio             (gpio),
        .o_bus_error        (berr)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic int unsigned size_of(input logic [2:0] len);
        case (len)
            3'b000:  return 1;
            3'b001:  return 2;
            3'b010:  return 4;
            default: return 0;
        endcase
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] a);
        logic [31:0] w;
        logic [11:0] bi;
        w = a & ~32'd3;
        if (w < DW*4) begin
            bi = w[11:0];
            return {mem_b[bi+12'd3], mem_b[bi+12'd2], mem_b[bi+12'd1], mem_b[bi]};
        end
        if (w >= BASE && w < BASE + 32'd64) begin
            case (w - BASE)
                32'd0:   return m_time[31:0];
                32'd4:   return m_time[63:32];
                32'd8:   return m_cmp[31:0];
                32'd12:  return m_cmp[63:32];
                32'd16:  return {30'b0, m_err, m_irq};
                32'd20:  return 32'(m_gpio);
                default: return 32'h0;
            endcase
        end
        return 32'h0;
    endfunction

    // One clock edge of the specified behaviour, in plain byte/64-bit arithmetic.
    task automatic model_edge(input logic w_en, input logic [31:0] a, input logic [31:0] d,
                              input logic [2:0] len);
        logic [63:0] nt, nc;
        logic [31:0] tmp;
        int unsigned sz;
        logic        ram_a, reg_a;
        nt = m_time + 64'd1;
        nc = m_cmp;
        if (w_en) begin
            sz    = size_of(len);
            ram_a = a < DW*4;
            reg_a = (a >= BASE) && (a < BASE + 32'd24);
            if (sz == 0 || (a % sz) != 0 || !(ram_a || reg_a)) begin
                m_err = 1'b1;
            end else if (ram_a) begin
                for (int unsigned i = 0; i < sz; i++) mem_b[12'(a + i)] = d[8*i +: 8];
            end else begin
                tmp = model_read(a);
                for (int unsigned i = 0; i < sz; i++) tmp[8*((a % 4) + i) +: 8] = d[8*i +: 8];
                case ((a - BASE) >> 2)
                    32'd0: nt = {m_time[63:32], tmp};
                    32'd1: nt[63:32] = tmp;
                    32'd2: nc[31:0] = tmp;
                    32'd3: nc[63:32] = tmp;
                    32'd4: if ((a % 4) == 0 && d[1]) m_err = 1'b0;
                    32'd5: m_gpio = tmp[GW-1:0];
                    default: ;
                endcase
            end
        end
        m_time = nt;
        m_cmp  = nc;
        m_irq  = (nt >= nc);
    endtask

    always @(posedge clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            m_time = '0;
            m_cmp  = '1;
            m_gpio = '0;
            m_err  = 1'b0;
            m_irq  = 1'b0;
        end else begin
            model_edge(we, addr, wdata, wlen);
        end
    end

    // Apply one store across the next rising edge; returns 1 ns after it.
    task automatic drive(input logic [31:0] a, input logic [31:0] d, input logic [2:0] len);
        addr  = a;
        wdata = d;
        wlen  = len;
        we    = 1'b1;
        @(posedge clk);
        #1;
        we = 1'b0;
    endtask

    // Move the read address at the next falling edge (no store).
    task automatic set_addr(input logic [31:0] a);
        @(negedge clk);
        we   = 1'b0;
        addr = a;
        #1;
    endtask

    task automatic test_reset;
        i_reset_n = 1'b0;
        repeat (3) @(posedge clk);
        set_addr(BASE + 32'h8);
        checks++;
        if (rdata !== 32'hFFFF_FFFF) begin
            failures++;
            $display("FAIL reset_cmp_lo: got %h expected ffffffff", rdata);
        end
        set_addr(BASE + 32'hC);
        checks++;
        if (rdata !== 32'hFFFF_FFFF) begin
            failures++;
            $display("FAIL reset_cmp_hi: got %h expected ffffffff", rdata);
        end
        checks++;
        if (gpio !== '0 || irq !== 1'b0 || berr !== 1'b0) begin
            failures++;
            $display("FAIL reset_outputs: gpio=%h irq=%b err=%b expected 0/0/0", gpio, irq, berr);
        end
        i_reset_n = 1'b1;
    endtask

    task automatic test_ram_lanes;
        drive(32'h10, 32'hDEAD_BEEF, 3'b010);
        drive(32'h11, 32'hFFFF_FF55, 3'b000);
        drive(32'h12, 32'h7777_A5A5, 3'b001);
        set_addr(32'h10);
        checks++;
        if (rdata !== 32'hA5A5_55EF) begin
            failures++;
            $display("FAIL ram_lane_merge: got %h expected a5a555ef", rdata);
        end
        drive(32'h23, 32'h0000_00C3, 3'b000);
        drive(32'h20, 32'h1234_5678, 3'b001);
        set_addr(32'h20);
        checks++;
        if (rdata[31:24] !== 8'hC3 || rdata[15:0] !== 16'h5678) begin
            failures++;
            $display("FAIL ram_byte3_half0: got %h expected c3xx5678", rdata);
        end
    endtask

    task automatic test_misaligned;
        drive(32'h13, 32'h0000_1234, 3'b001);
        checks++;
        if (berr !== 1'b1) begin
            failures++;
            $display("FAIL misaligned_half_err: got %b expected 1", berr);
        end
        drive(32'h06, 32'h0BAD_F00D, 3'b010);
        drive(32'h10, 32'h0BAD_F00D, 3'b011);
        set_addr(32'h10);
        checks++;
        if (rdata !== 32'hA5A5_55EF) begin
            failures++;
            $display("FAIL misaligned_no_write: got %h expected a5a555ef", rdata);
        end
        drive(BASE + 32'h10, 32'h0000_0002, 3'b010);
        checks++;
        if (berr !== 1'b0) begin
            failures++;
            $display("FAIL status_w1c: got %b expected 0", berr);
        end
    endtask

    task automatic test_mtime_carry;
        drive(BASE, 32'hFFFF_FFFE, 3'b010);
        repeat (3) @(posedge clk);
        set_addr(BASE);
        checks++;
        if (rdata !== 32'h0000_0001) begin
            failures++;
            $display("FAIL mtime_lo_carry: got %h expected 00000001", rdata);
        end
        set_addr(BASE + 32'h4);
        checks++;
        if (rdata !== 32'h0000_0001) begin
            failures++;
            $display("FAIL mtime_hi_carry: got %h expected 00000001", rdata);
        end
    endtask

    task automatic test_timer_irq;
        logic [31:0] target;
        logic        hit;
        drive(BASE + 32'h4, 32'h0, 3'b010);
        drive(BASE + 32'hC, 32'h0, 3'b010);
        target = m_time[31:0] + 32'd6;
        drive(BASE + 32'h8, target, 3'b010);
        hit = 1'b0;
        for (int i = 0; i < 12 && !hit; i++) begin
            checks++;
            if (irq !== m_irq) begin
                failures++;
                $display("FAIL irq_track: got %b expected %b at mtime %h", irq, m_irq, m_time);
            end
            if (m_time[31:0] == target) begin
                hit = 1'b1;
                checks++;
                if (irq !== 1'b1) begin
                    failures++;
                    $display("FAIL irq_rise: got %b expected 1", irq);
                end
            end else begin
                @(posedge clk);
                #1;
            end
        end
        if (!hit) begin
            checks++;
            failures++;
            $display("FAIL irq_timeout: mtime never reached %h", target);
        end
        set_addr(BASE + 32'h10);
        checks++;
        if (rdata[0] !== 1'b1) begin
            failures++;
            $display("FAIL status_pending: got %b expected 1", rdata[0]);
        end
        drive(BASE + 32'hC, 32'h1, 3'b010);
        checks++;
        if (irq !== 1'b0) begin
            failures++;
            $display("FAIL irq_fall: got %b expected 0", irq);
        end
    endtask

    task automatic test_gpio_unmapped;
        drive(BASE + 32'h14, 32'hFFFF_FF3C, 3'b010);
        checks++;
        if (gpio !== 8'h3C) begin
            failures++;
            $display("FAIL gpio_out: got %h expected 3c", gpio);
        end
        drive(BASE + 32'h15, 32'h0000_0099, 3'b000);
        set_addr(BASE + 32'h14);
        checks++;
        if (rdata !== 32'h0000_003C) begin
            failures++;
            $display("FAIL gpio_read: got %h expected 0000003c", rdata);
        end
        set_addr(BASE + 32'h20);
        checks++;
        if (rdata !== 32'h0) begin
            failures++;
            $display("FAIL unmapped_mmio_read: got %h expected 0", rdata);
        end
        set_addr(32'h2000_0000);
        checks++;
        if (rdata !== 32'h0) begin
            failures++;
            $display("FAIL unmapped_read: got %h expected 0", rdata);
        end
        drive(BASE + 32'h20, $urandom, 3'b010);
        checks++;
        if (berr !== 1'b1) begin
            failures++;
            $display("FAIL unmapped_write_err: got %b expected 1", berr);
        end
    endtask

    task automatic test_reset_midop;
        @(negedge clk);
        addr  = BASE + 32'h14;
        wdata = 32'h0000_00AA;
        wlen  = 3'b010;
        we    = 1'b1;
        #2;
        i_reset_n = 1'b0;
        #1;
        checks++;
        if (gpio !== '0 || berr !== 1'b0 || irq !== 1'b0) begin
            failures++;
            $display("FAIL async_reset: gpio=%h err=%b irq=%b expected 0/0/0", gpio, berr, irq);
        end
        @(posedge clk);
        #1;
        checks++;
        if (gpio !== '0) begin
            failures++;
            $display("FAIL reset_write_lost: got %h expected 00", gpio);
        end
        we = 1'b0;
        i_reset_n = 1'b1;
        set_addr(BASE + 32'h8);
        checks++;
        if (rdata !== m_cmp[31:0]) begin
            failures++;
            $display("FAIL reset_cmp_restored: got %h expected %h", rdata, m_cmp[31:0]);
        end
    endtask

    task automatic test_random;
        logic [31:0] exp;
        int unsigned k, r;
        for (int unsigned w = 0; w < 16; w++) drive(4 * w, $urandom, 3'b010);
        for (int n = 0; n < 300; n++) begin
            k = $urandom_range(0, 9);
            @(negedge clk);
            if (k < 5)      addr = 32'($urandom_range(0, 63));
            else if (k == 5) addr = BASE + 32'($urandom_range(0, 7));
            else if (k < 8) addr = BASE + 32'($urandom_range(8, 23));
            else if (k == 8) addr = BASE + 32'($urandom_range(24, 63));
            else            addr = $urandom;
            r     = $urandom_range(0, 7);
            wlen  = (r < 6) ? 3'(r % 3) : 3'(r);
            wdata = $urandom;
            we    = ($urandom_range(0, 3) != 0);
            #1;
            exp = model_read(addr);
            if (!$isunknown(exp)) begin
                checks++;
                if (rdata !== exp) begin
                    failures++;
                    $display("FAIL rand_read: addr %h got %h expected %h", addr, rdata, exp);
                end
            end
            @(posedge clk);
            #1;
            we = 1'b0;
            checks++;
            if (berr !== m_err || gpio !== m_gpio || irq !== m_irq) begin
                failures++;
                $display("FAIL rand_state: err=%b gpio=%h irq=%b expected %b/%h/%b",
                         berr, gpio, irq, m_err, m_gpio, m_irq);
            end
        end
    endtask

    initial begin
        test_reset();
        test_ram_lanes();
        test_misaligned();
        test_mtime_carry();
        test_timer_irq();
        test_gpio_unmapped();
        test_reset_midop();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
